// File: rtl/flag_branch_unit.sv
// NZCV flag register plus branch resolver for B.cond, CBZ and B.
// The branch result comes out registered, one cycle after the request is accepted.
module flag_branch_unit #(
  parameter int unsigned COND_W      = 4,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_negative,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_carry_out,
  input  logic              set_flags,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [COND_W-1:0] br_cond,
  output logic [3:0]        flags_q,
  output logic              br_done,
  output logic              br_taken,
  output logic              br_err
);

  localparam logic [1:0] BR_BCOND = 2'b00;
  localparam logic [1:0] BR_CBZ   = 2'b01;
  localparam logic [1:0] BR_B     = 2'b10;

  typedef enum logic {S_IDLE, S_RESOLVE} state_e;

  state_e     state_q;
  logic       br_taken_q;
  logic       br_err_q;
  logic [3:0] alu_flags_c;
  logic [3:0] eff_flags_c;
  logic [3:0] cond_c;
  logic       n_c, z_c, c_c, v_c;
  logic       taken_c;
  logic       err_c;

  assign alu_flags_c = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
  assign cond_c      = 4'(br_cond);

  // A flag-setting op fused with a branch is evaluated on the fresh ALU flags.
  assign eff_flags_c = (set_flags && br_valid) ? alu_flags_c : flags_q;
  assign {n_c, z_c, c_c, v_c} = eff_flags_c;

  // Branch decision for the request presented this cycle.
  always_comb begin
    taken_c = 1'b0;
    err_c   = 1'b0;
    case (br_type)
      BR_BCOND: begin
        case (cond_c)
          4'b0000: taken_c = z_c;
          4'b0001: taken_c = !z_c;
          4'b0010: taken_c = c_c;
          4'b0011: taken_c = !c_c;
          4'b0100: taken_c = n_c;
          4'b0101: taken_c = !n_c;
          4'b0110: taken_c = v_c;
          4'b0111: taken_c = !v_c;
          4'b1000: taken_c = c_c && !z_c;
          4'b1001: taken_c = !c_c || z_c;
          4'b1010: taken_c = (n_c == v_c);
          4'b1011: taken_c = (n_c != v_c);
          4'b1100: taken_c = !z_c && (n_c == v_c);
          4'b1101: taken_c = z_c || (n_c != v_c);
          4'b1110: taken_c = 1'b1;
          default: err_c   = 1'b1;
        endcase
      end
      BR_CBZ:  taken_c = alu_zero;
      BR_B:    taken_c = 1'b1;
      default: err_c   = 1'b1;
    endcase
  end

  // Flag register and output sequencer; stall freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= RESET_FLAGS;
      state_q    <= S_IDLE;
      br_taken_q <= 1'b0;
      br_err_q   <= 1'b0;
    end else if (!stall) begin
      if (set_flags) begin
        flags_q <= alu_flags_c;
      end
      if (br_valid) begin
        state_q    <= S_RESOLVE;
        br_taken_q <= taken_c;
        br_err_q   <= err_c;
      end else begin
        state_q    <= S_IDLE;
        br_taken_q <= 1'b0;
        br_err_q   <= 1'b0;
      end
    end
  end

  assign br_done  = (state_q == S_RESOLVE);
  assign br_taken = br_taken_q;
  assign br_err   = br_err_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed scenarios plus random traffic against a cycle-level reference model.
module tb_flag_branch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
  logic       set_flags, stall, br_valid;
  logic [1:0] br_type;
  logic [3:0] br_cond;
  logic [3:0] flags_q;
  logic       br_done, br_taken, br_err;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m_flags;
  logic       m_done, m_taken, m_err;

  flag_branch_unit #(.COND_W(4), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .reset(reset),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .set_flags(set_flags), .stall(stall), .br_valid(br_valid),
    .br_type(br_type), .br_cond(br_cond),
    .flags_q(flags_q), .br_done(br_done), .br_taken(br_taken), .br_err(br_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Condition codes come in pairs: even code tests a predicate, odd code its negation.
  function automatic bit cond_holds(input int code, input bit n, input bit z, input bit c, input bit v);
    bit base;
    if (code == 14) return 1'b1;
    if (code == 15) return 1'b0;
    case (code / 2)
      0: base = z;
      1: base = c;
      2: base = n;
      3: base = v;
      4: base = c && !z;
      5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return (code % 2 == 1) ? !base : base;
  endfunction

  task automatic model_update();
    logic [3:0] eff;
    logic [3:0] alu;
    alu = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    if (reset) begin
      m_flags = 4'b0000; m_done = 0; m_taken = 0; m_err = 0;
    end else if (!stall) begin
      eff = (set_flags && br_valid) ? alu : m_flags;
      if (set_flags) m_flags = alu;
      if (br_valid) begin
        m_done = 1;
        m_err  = (br_type == 2'b11) || (br_type == 2'b00 && br_cond == 4'hF);
        case (br_type)
          2'b00:   m_taken = cond_holds(int'(br_cond), eff[3], eff[2], eff[1], eff[0]);
          2'b01:   m_taken = alu_zero;
          2'b10:   m_taken = 1;
          default: m_taken = 0;
        endcase
      end else begin
        m_done = 0; m_taken = 0; m_err = 0;
      end
    end
  endtask

  // One clock: inputs already driven, advance model, compare all outputs just after the edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check("flags", 8'(flags_q), 8'(m_flags));
    check("done",  8'(br_done), 8'(m_done));
    check("taken", 8'(br_taken), 8'(m_taken));
    check("err",   8'(br_err), 8'(m_err));
  endtask

  task automatic idle_inputs();
    reset = 0; set_flags = 0; stall = 0; br_valid = 0;
    br_type = 2'b00; br_cond = 4'h0;
    alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
  endtask

  task automatic set_alu(input logic [3:0] nzcv);
    {alu_negative, alu_zero, alu_carry_out, alu_overflow} = nzcv;
  endtask

  int sweep_exp [16] = '{1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0};

  initial begin
    m_flags = 0; m_done = 0; m_taken = 0; m_err = 0;
    idle_inputs();

    // Reset with toggling inputs; request during reset is dropped.
    for (int i = 0; i < 2; i++) begin
      reset = 1; set_flags = 1; stall = 1'($urandom); br_valid = 1;
      br_type = 2'($urandom); br_cond = 4'($urandom); set_alu(4'($urandom) | 4'b0001);
      cycle();
      check("rst_flags", 8'(flags_q), 8'h0);
      check("rst_done", 8'(br_done), 8'h0);
    end
    idle_inputs();
    cycle();
    check("rst_req_dropped", 8'(br_done), 8'h0);

    // Flag capture and hold.
    set_flags = 1; set_alu(4'b1010);
    cycle();
    check("capture", 8'(flags_q), 8'hA);
    set_flags = 0; set_alu(4'b0101);
    cycle();
    check("capture_hold", 8'(flags_q), 8'hA);

    // Condition sweep with Z=1 only.
    set_flags = 1; set_alu(4'b0100);
    cycle();
    set_flags = 0; set_alu(4'b0000);
    for (int i = 0; i < 16; i++) begin
      br_valid = 1; br_type = 2'b00; br_cond = 4'(i);
      cycle();
      check($sformatf("sweep_done_%0d", i), 8'(br_done), 8'h1);
      check($sformatf("sweep_taken_%0d", i), 8'(br_taken), 8'(sweep_exp[i]));
      check($sformatf("sweep_err_%0d", i), 8'(br_err), 8'(i == 15));
    end
    idle_inputs();
    cycle();

    // Fused flag-set + B.cond EQ sees the incoming Z.
    set_flags = 1; set_alu(4'b0000);
    cycle();
    set_flags = 1; set_alu(4'b0100); br_valid = 1; br_type = 2'b00; br_cond = 4'h0;
    cycle();
    check("bypass_taken", 8'(br_taken), 8'h1);
    check("bypass_flags", 8'(flags_q), 8'h4);

    // CBZ, B and reserved type (flags_q Z=1 here).
    idle_inputs(); br_valid = 1; br_type = 2'b01; alu_zero = 1;
    cycle();
    check("cbz_zero", 8'(br_taken), 8'h1);
    alu_zero = 0;
    cycle();
    check("cbz_nonzero", 8'(br_taken), 8'h0);
    br_type = 2'b10;
    cycle();
    check("b_taken", 8'(br_taken), 8'h1);
    br_type = 2'b11;
    cycle();
    check("rsvd_taken", 8'(br_taken), 8'h0);
    check("rsvd_err", 8'(br_err), 8'h1);

    // Stall holds the reserved-type result and flags for three cycles.
    stall = 1; br_type = 2'b10; set_flags = 1; set_alu(4'b1011);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_flags", 8'(flags_q), 8'h4);
      check("stall_done", 8'(br_done), 8'h1);
      check("stall_err", 8'(br_err), 8'h1);
    end
    stall = 0; set_flags = 0;
    cycle();
    check("unstall_done", 8'(br_done), 8'h1);
    check("unstall_taken", 8'(br_taken), 8'h1);
    check("unstall_err", 8'(br_err), 8'h0);
    idle_inputs();
    cycle();
    check("unstall_single", 8'(br_done), 8'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 31) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      set_flags = 1'($urandom);
      br_valid  = ($urandom_range(0, 2) != 0);
      br_type   = 2'($urandom);
      br_cond   = 4'($urandom);
      set_alu(4'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_branch_unit.md
Name: flag_branch_unit

Overview:
- Consumes the ALU's status outputs (negative, zero, overflow, carry_out).
- Holds the architectural NZCV flag register, updated only by flag-setting operations (ADDS/SUBS class).
- Resolves branch decisions for B.cond, CBZ and B from those flags.
- Sits between the execute stage and fetch/PC-select logic; result is registered, one cycle after the request.

Parameters:
- COND_W, 4, width of the branch condition code field.
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset (bit order N,Z,C,V from msb).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state on the clock edge where it is high
- alu_negative  input  1  ALU negative flag for the current execute op
- alu_zero  input  1  ALU zero flag (64-bit result == 0)
- alu_overflow  input  1  ALU signed overflow flag
- alu_carry_out  input  1  ALU carry out (for subtract, 1 = no borrow)
- set_flags  input  1  current op writes NZCV
- stall  input  1  freeze: no flag update, no branch acceptance, outputs held
- br_valid  input  1  branch request present this cycle
- br_type  input  2  00 B.cond, 01 CBZ, 10 B (unconditional), 11 reserved
- br_cond  input  COND_W  ARM-style condition code for B.cond
- flags_q  output  4  registered NZCV
- br_done  output  1  one-cycle pulse: resolution of the accepted branch
- br_taken  output  1  branch decision, meaningful when br_done=1
- br_err  output  1  one-cycle pulse alongside br_done for reserved br_type or cond 4'b1111

Behaviour:
- Reset:
  - flags_q=RESET_FLAGS; br_done=0, br_taken=0, br_err=0.
  - reset has priority over stall and all inputs.
  - A request presented in the reset cycle is discarded; no br_done follows.
- Flag register:
  - On edge with !stall && set_flags, flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}.
  - Otherwise flags_q holds.
- Effective flags for evaluation:
  - If set_flags && br_valid in the same cycle, use the incoming ALU flags (bypass).
  - Otherwise use flags_q.
  - This models a fused flag-set + branch.
- Branch acceptance:
  - A request is accepted on an edge with br_valid && !stall && !reset.
  - Next cycle br_done=1 with br_taken/br_err; otherwise br_done=0, br_err=0, br_taken=0.
  - Latency is exactly 1 cycle.
  - Back-to-back requests each get their own br_done pulse.
- Stall:
  - While stall=1, br_done, br_taken and br_err hold their previous values.
  - A br_done pulse that was high is therefore stretched; the consumer qualifies it with !stall.
- Decision per br_type:
  - B: taken=1.
  - CBZ: taken=alu_zero (ALU run in pass-B mode); flags are not consulted.
  - reserved: taken=0, err=1.
- B.cond decision, where N,Z,C,V are the effective flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 HS: C
  - 0011 LO: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 NV: taken=0, err=1
- br_cond is ignored unless br_type=00.
- A branch never modifies flags unless set_flags is also high.
- Implementation is a 2-state output sequencer:
  - IDLE: br_done=0.
  - RESOLVE: br_done=1.
  - IDLE->RESOLVE on accept; RESOLVE->RESOLVE on accept; RESOLVE->IDLE otherwise.
  - Either state holds on stall; reset forces IDLE.

Test Plan:
- Reset and reset-cycle request:
  - Assert reset 2 cycles with all inputs toggling -> flags_q=0000, br_done=0.
  - br_valid=1 during the reset cycle -> no br_done afterwards.
- Flag capture:
  - set_flags=1 with N=1,Z=0,C=1,V=0 -> flags_q=4'b1010 next cycle.
  - Following cycle with set_flags=0 and changed ALU flags -> flags_q stays 4'b1010.
- Condition sweep:
  - Preload flags_q=0100 (Z=1), issue all 16 B.cond codes back-to-back.
  - Required br_taken per code 0..15: 1,0,0,1,0,1,0,1,0,1,1,0,0,1,1,0.
  - br_err only for 1111; 16 consecutive br_done pulses.
- Bypass:
  - flags_q=0000, same cycle set_flags=1 with Z=1 and br_valid B.cond EQ -> br_taken=1 next cycle, flags_q=0100.
- CBZ/B/reserved:
  - CBZ with alu_zero=1 -> taken=1.
  - CBZ with alu_zero=0 while flags_q Z=1 -> taken=0.
  - B -> taken=1.
  - br_type=11 -> taken=0, br_err=1.
- Stall:
  - br_valid held with stall=1 for 3 cycles -> flags_q unchanged, outputs held.
  - Release stall -> exactly one br_done one cycle later.
